mnist_frame_packer: RTL and testbench

Upstream stage of the MNIST LUT-network inference path. Accepts a raster pixel stream, one 8-bit grey pixel per handshake, binarizes each pixel against a fixed threshold, and packs a full 28×28 frame into the 784-bit parallel vector the LUT MLP consumes on its `in_data` port. The frame label travels alongside the frame on `m_user`, so downstream scoring can compare `out_data` against `1 << out_user`. Double-buffered, so capture of frame n+1 overlaps presentation of frame n.

---
 rtl/mnist_pkg.sv | 15 +
 rtl/mnist_pixel_threshold.sv | 12 +
 rtl/mnist_frame_packer.sv | 130 +++++++++++++
 tb/tb_mnist_frame_packer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and FSM state type for the MNIST LUT-network inference path.
package mnist_pkg;

    localparam int MNIST_IMG_W        = 28;
    localparam int MNIST_IMG_H        = 28;
    localparam int MNIST_INPUT_WIDTH  = MNIST_IMG_W * MNIST_IMG_H;
    localparam int MNIST_OUTPUT_WIDTH = 10;
    localparam int MNIST_USER_WIDTH   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

endpackage

// File: rtl/mnist_pixel_threshold.sv
// Combinational binarizer: bit is 1 iff the unsigned pixel exceeds THRESHOLD.
module mnist_pixel_threshold #(
    parameter int PIXEL_WIDTH = 8,
    parameter int THRESHOLD   = 127
) (
    input  logic [PIXEL_WIDTH-1:0] pixel_i,
    output logic                   bit_o
);

    assign bit_o = (pixel_i > PIXEL_WIDTH'(THRESHOLD));

endmodule

// File: rtl/mnist_frame_packer.sv
// Packs a binarized raster frame into one parallel vector with its label; double-buffered.
// One pixel per cycle, m_valid pulses one cycle after the last pixel; no downstream backpressure.
module mnist_frame_packer
    import mnist_pkg::*;
#(
    parameter int USER_WIDTH  = MNIST_USER_WIDTH,
    parameter int IMG_W       = MNIST_IMG_W,
    parameter int IMG_H       = MNIST_IMG_H,
    parameter int PIXEL_WIDTH = 8,
    parameter int THRESHOLD   = 127,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cke,
    input  logic [USER_WIDTH-1:0]    s_user,
    input  logic [PIXEL_WIDTH-1:0]   s_pixel,
    input  logic                     s_first,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [USER_WIDTH-1:0]    m_user,
    output logic [IMG_W*IMG_H-1:0]   m_data,
    output logic                     m_valid,
    output logic [CNT_WIDTH-1:0]     frame_count,
    output logic [CNT_WIDTH-1:0]     drop_count
);

    localparam int NPIX  = IMG_W * IMG_H;
    localparam int IDX_W = $clog2(NPIX);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NPIX-1:0]        fill_q, fill_d;
    logic [USER_WIDTH-1:0]  fill_user_q, fill_user_d;
    logic [NPIX-1:0]        data_q, data_d;
    logic [USER_WIDTH-1:0]  user_q, user_d;
    logic                   valid_q, valid_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic accept;
    logic pix_bit;

    assign s_ready = cke & ~reset;
    assign accept  = s_valid & s_ready;

    mnist_pixel_threshold #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .THRESHOLD   (THRESHOLD)
    ) u_threshold (
        .pixel_i (s_pixel),
        .bit_o   (pix_bit)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        fill_d      = fill_q;
        fill_user_d = fill_user_q;
        data_d      = data_q;
        user_d      = user_q;
        valid_d     = 1'b0;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (accept) begin
            if (s_first) begin
                // A first pixel while filling abandons the partial frame.
                if (state_q == FILL) begin
                    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
                end
                fill_d[0]   = pix_bit;
                fill_user_d = s_user;
                idx_d       = IDX_W'(1);
                state_d     = FILL;
            end else if (state_q == IDLE) begin
                drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
            end else begin
                fill_d[idx_q] = pix_bit;
                if (idx_q == LAST_IDX) begin
                    data_d      = fill_d;
                    user_d      = fill_user_q;
                    valid_d     = 1'b1;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
                    idx_d       = '0;
                    state_d     = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            fill_user_q <= '0;
            data_q      <= '0;
            user_q      <= '0;
            valid_q     <= 1'b0;
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else if (cke) begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fill_user_q <= fill_user_d;
            data_q      <= data_d;
            user_q      <= user_d;
            valid_q     <= valid_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Unwritten fill bits are never presented, so the capture buffer needs no reset.
    always_ff @(posedge clk) begin
        if (cke) begin
            fill_q <= fill_d;
        end
    end

    assign m_user      = user_q;
    assign m_data      = data_q;
    assign m_valid     = valid_q;
    assign frame_count = frame_cnt_q;
    assign drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_mnist_frame_packer.sv
// Directed + randomized bench for mnist_frame_packer against a frame-level reference model.
module tb_mnist_frame_packer;

    localparam int NPIX = 784;

    logic              clk = 1'b0;
    logic              reset;
    logic              cke;
    logic [7:0]        s_user;
    logic [7:0]        s_pixel;
    logic              s_first;
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        m_user;
    logic [NPIX-1:0]   m_data;
    logic              m_valid;
    logic [15:0]       frame_count;
    logic [15:0]       drop_count;

    always #5 clk = ~clk;

    mnist_frame_packer dut (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .s_user      (s_user),
        .s_pixel     (s_pixel),
        .s_first     (s_first),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .m_user      (m_user),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the pixels of the frame in progress, and what should be presented.
    int              pixq[$];
    bit              in_frame   = 1'b0;
    logic [7:0]      cur_user   = '0;
    logic [NPIX-1:0] exp_data   = '0;
    logic [7:0]      exp_user   = '0;
    logic            exp_valid  = 1'b0;
    int              exp_frames = 0;
    int              exp_drops  = 0;

    int  cyc        = 0;
    bit  spacing_on = 1'b0;
    int  last_pulse = -1;

    task automatic chk(input string tag, input logic [NPIX-1:0] obs, input logic [NPIX-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            pixq.delete();
            in_frame   = 1'b0;
            exp_data   = '0;
            exp_user   = '0;
            exp_valid  = 1'b0;
            exp_frames = 0;
            exp_drops  = 0;
        end else if (cke) begin
            exp_valid = 1'b0;
            if (s_valid) begin
                if (s_first) begin
                    if (in_frame) exp_drops++;
                    pixq.delete();
                    pixq.push_back(int'(s_pixel));
                    cur_user = s_user;
                    in_frame = 1'b1;
                end else if (!in_frame) begin
                    exp_drops++;
                end else begin
                    pixq.push_back(int'(s_pixel));
                    if (pixq.size() == NPIX) begin
                        for (int i = 0; i < NPIX; i++) exp_data[i] = (pixq[i] > 127);
                        exp_user  = cur_user;
                        exp_valid = 1'b1;
                        exp_frames++;
                        in_frame  = 1'b0;
                        pixq.delete();
                    end
                end
            end
        end
        chk("s_ready", s_ready, cke & ~reset);
        chk("m_valid", m_valid, exp_valid);
        chk("m_data", m_data, exp_data);
        chk("m_user", m_user, exp_user);
        chk("frame_count", frame_count, 16'(exp_frames));
        chk("drop_count", drop_count, 16'(exp_drops));
        if (spacing_on && m_valid === 1'b1) begin
            if (last_pulse >= 0) chk("pulse_spacing", cyc - last_pulse, NPIX);
            last_pulse = cyc;
        end
    endtask

    task automatic send(input logic [7:0] pix, input logic first, input logic [7:0] user);
        s_valid = 1'b1;
        s_pixel = pix;
        s_first = first;
        s_user  = user;
        tick();
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic rand_pixels(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 7) == 0) idle(1);
            send(rnd8(), 1'b0, rnd8());
        end
    endtask

    logic [NPIX-1:0] even_pat;

    initial begin
        reset   = 1'b1;
        cke     = 1'b1;
        s_valid = 1'b0;
        s_first = 1'b0;
        s_user  = '0;
        s_pixel = '0;
        even_pat = {392{2'b01}};

        repeat (100) tick();
        reset = 1'b0;
        idle(2);

        // Single frame: alternating 255/0 pixels, label 7.
        for (int i = 0; i < NPIX; i++) send((i % 2 == 0) ? 8'd255 : 8'd0, i == 0, 8'd7);
        chk("single_valid", m_valid, 1'b1);
        chk("single_data", m_data, even_pat);
        chk("single_user", m_user, 8'd7);
        chk("single_frames", frame_count, 16'd1);
        idle(3);

        // Threshold edge at indices 0 and 1.
        send(8'd127, 1'b1, rnd8());
        send(8'd128, 1'b0, rnd8());
        rand_pixels(NPIX - 2, 1'b0);
        chk("thresh_bit0", m_data[0], 1'b0);
        chk("thresh_bit1", m_data[1], 1'b1);
        idle(2);

        // Back-to-back random frames with no gaps.
        spacing_on = 1'b1;
        last_pulse = -1;
        for (int f = 0; f < 6; f++) begin
            send(rnd8(), 1'b1, rnd8());
            rand_pixels(NPIX - 1, 1'b0);
        end
        spacing_on = 1'b0;
        chk("b2b_drops", drop_count, 16'd0);
        chk("b2b_frames", frame_count, 16'd8);

        // Frame with random idle gaps.
        send(rnd8(), 1'b1, rnd8());
        rand_pixels(NPIX - 1, 1'b1);
        idle(2);

        // Mid-frame restart at index 400.
        send(rnd8(), 1'b1, 8'd9);
        rand_pixels(399, 1'b0);
        send(rnd8(), 1'b1, 8'd3);
        rand_pixels(NPIX - 1, 1'b0);
        chk("restart_user", m_user, 8'd3);
        chk("restart_drops", drop_count, 16'd1);
        chk("restart_frames", frame_count, 16'd10);
        idle(2);

        // Stray pixels in IDLE.
        for (int i = 0; i < 5; i++) send(rnd8(), 1'b0, rnd8());
        chk("stray_drops", drop_count, 16'd6);
        idle(2);

        // Clock-enable stall mid-frame and across the m_valid cycle.
        send(rnd8(), 1'b1, rnd8());
        rand_pixels(299, 1'b0);
        cke = 1'b0;
        s_valid = 1'b1;
        repeat (20) tick();
        cke = 1'b1;
        rand_pixels(NPIX - 300, 1'b0);
        cke = 1'b0;
        repeat (20) tick();
        chk("stall_valid_held", m_valid, 1'b1);
        cke = 1'b1;
        idle(1);
        chk("stall_valid_drop", m_valid, 1'b0);
        chk("stall_frames", frame_count, 16'd11);

        // Reset at index 300, then a clean frame.
        send(rnd8(), 1'b1, rnd8());
        rand_pixels(299, 1'b0);
        reset = 1'b1;
        s_valid = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        idle(1);
        send(rnd8(), 1'b1, 8'd5);
        rand_pixels(NPIX - 1, 1'b0);
        chk("rst_valid", m_valid, 1'b1);
        chk("rst_user", m_user, 8'd5);
        chk("rst_frames", frame_count, 16'd1);
        chk("rst_drops", drop_count, 16'd0);
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
